// File: rtl/j22_intc_if.sv
// Register bus and CPU interrupt handshake for the J22 interrupt controller.
interface j22_intc_if;
  logic        bus_sel;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        intr_req;
  logic [4:0]  intr_level;
  logic [7:0]  intr_vec;
  logic        inta_ack;

  // CPU / bus master side
  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata, inta_ack,
    input  bus_rdata, bus_ack, intr_req, intr_level, intr_vec
  );

  // Interrupt controller side
  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata, inta_ack,
    output bus_rdata, bus_ack, intr_req, intr_level, intr_vec
  );
endinterface

// File: rtl/j22_intc.sv
// J22 interrupt controller: NSRC prioritised sources plus edge-triggered NMI,
// arbitrated against the CPU mask and presented on a req/level/vec handshake.
module j22_intc #(
  parameter int unsigned NSRC     = 8,
  parameter logic [7:0]  VEC_BASE = 8'h40,
  parameter logic [7:0]  NMI_VEC  = 8'h0B
) (
  input  logic            clk,
  input  logic            rst,
  j22_intc_if.slave       bus,
  input  logic [NSRC-1:0] irq_src,
  input  logic            nmi,
  input  logic [3:0]      imask
);

  logic [3:0]      cfg_prio [NSRC];
  logic [7:0]      cfg_vec  [NSRC];
  logic [NSRC-1:0] cfg_edge;

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] irq_prev;
  logic            nmi_pend;
  logic            nmi_prev;

  logic [3:0]      pres_id;
  logic            pres_nmi;

  logic [NSRC-1:0] rise;
  logic            nmi_rise;
  logic [NSRC-1:0] active;
  logic            win_nmi;
  logic            win_any;
  logic [3:0]      win_id;
  logic [3:0]      win_prio;
  logic [7:0]      win_vec;

  logic [5:0]      widx;
  logic            cfg_wr;
  logic            pend_wr;
  logic            ack_ok;
  logic [NSRC-1:0] w1c_clr;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] pend_nxt;
  logic            nmi_pend_nxt;
  logic [15:0]     src16;
  logic [31:0]     rd_data;
  logic            unused_bits;

  assign widx     = bus.bus_addr[7:2];
  assign cfg_wr   = bus.bus_sel & bus.bus_we & (widx < 6'(NSRC));
  assign pend_wr  = bus.bus_sel & bus.bus_we & (widx == 6'd16);
  assign ack_ok   = bus.inta_ack & bus.intr_req;
  assign rise     = irq_src & ~irq_prev;
  assign nmi_rise = nmi & ~nmi_prev;
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:17], bus.bus_wdata[15:12]};

  // Edge sources count as active in the cycle of their rising edge so that
  // the request appears one edge after the event rather than two.
  always_comb begin
    active = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      active[k] = cfg_edge[k] ? (pend[k] | rise[k]) : irq_src[k];
    end
  end

  // Arbitration: NMI first, else highest prio above imask, lowest index on ties
  always_comb begin
    win_nmi  = nmi_pend | nmi_rise;
    win_any  = 1'b0;
    win_id   = '0;
    win_prio = '0;
    win_vec  = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (active[k] && (cfg_prio[k] > imask) && (cfg_prio[k] > win_prio)) begin
        win_any  = 1'b1;
        win_id   = 4'(k);
        win_prio = cfg_prio[k];
        win_vec  = cfg_vec[k];
      end
    end
  end

  // Pending-bit next state: clears from W1C and ack, a new edge always wins
  always_comb begin
    w1c_clr = pend_wr ? bus.bus_wdata[NSRC-1:0] : '0;
    ack_clr = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (ack_ok && !pres_nmi && (pres_id == 4'(k))) ack_clr[k] = 1'b1;
    end
    pend_nxt     = ((pend & ~w1c_clr & ~ack_clr) | rise) & cfg_edge;
    nmi_pend_nxt = (nmi_pend & ~(ack_ok & pres_nmi)) | nmi_rise;
  end

  // Register read mux
  always_comb begin
    src16          = '0;
    src16[NSRC-1:0] = irq_src;
    rd_data        = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (widx == 6'(k)) rd_data = {15'd0, cfg_edge[k], 4'd0, cfg_vec[k], cfg_prio[k]};
    end
    if (widx == 6'd16) rd_data[NSRC-1:0] = pend;
    if (widx == 6'd17) rd_data = {10'd0, bus.intr_req, pres_id, nmi_pend, src16};
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (rst) begin
        cfg_prio[k] <= '0;
        cfg_vec[k]  <= VEC_BASE + 8'(k);
        cfg_edge[k] <= 1'b0;
      end else if (cfg_wr && (widx == 6'(k))) begin
        cfg_prio[k] <= bus.bus_wdata[3:0];
        cfg_vec[k]  <= bus.bus_wdata[11:4];
        cfg_edge[k] <= bus.bus_wdata[16];
      end
    end
  end

  // Source sampling and pending state
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      irq_prev <= '0;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      irq_prev <= irq_src;
      nmi_pend <= nmi_pend_nxt;
      nmi_prev <= nmi;
    end
  end

  // Presented interrupt; an accepted ack forces a one-cycle gap
  always_ff @(posedge clk) begin
    if (rst || ack_ok) begin
      bus.intr_req   <= 1'b0;
      bus.intr_level <= '0;
      bus.intr_vec   <= '0;
      pres_id        <= '0;
      pres_nmi       <= 1'b0;
    end else if (win_nmi) begin
      bus.intr_req   <= 1'b1;
      bus.intr_level <= 5'h1F;
      bus.intr_vec   <= NMI_VEC;
      pres_id        <= '0;
      pres_nmi       <= 1'b1;
    end else if (win_any) begin
      bus.intr_req   <= 1'b1;
      bus.intr_level <= {1'b0, win_prio};
      bus.intr_vec   <= win_vec;
      pres_id        <= win_id;
      pres_nmi       <= 1'b0;
    end else begin
      bus.intr_req   <= 1'b0;
      bus.intr_level <= '0;
      bus.intr_vec   <= '0;
      pres_id        <= '0;
      pres_nmi       <= 1'b0;
    end
  end

  // Bus response: ack one cycle after sel, read data registered alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      bus.bus_ack   <= bus.bus_sel;
      bus.bus_rdata <= (bus.bus_sel && !bus.bus_we) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_j22_intc.sv
// Self-checking bench for j22_intc: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_j22_intc;
  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic            nmi = 1'b0;
  logic [3:0]      imask = '0;

  int n_tests = 0;
  int n_fail  = 0;

  j22_intc_if bi ();

  j22_intc #(.NSRC(NSRC), .VEC_BASE(8'h40), .NMI_VEC(8'h0B)) dut (
    .clk(clk), .rst(rst), .bus(bi), .irq_src(src), .nmi(nmi), .imask(imask)
  );

  always #5 clk = ~clk;

  // Model state
  logic [3:0] m_prio [NSRC];
  logic [7:0] m_vecs [NSRC];
  logic       m_edge [NSRC];
  logic       m_pend [NSRC];
  logic       m_prev [NSRC];
  logic       m_nmi_pend, m_nmi_prev;
  logic       m_req, m_isnmi;
  logic [4:0] m_level;
  logic [7:0] m_vout;
  logic [3:0] m_id;
  logic       m_back;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NSRC; k++) begin
      m_prio[k] = '0;
      m_vecs[k] = 8'h40 + 8'(k);
      m_edge[k] = 1'b0;
      m_pend[k] = 1'b0;
      m_prev[k] = 1'b0;
    end
    m_nmi_pend = 0; m_nmi_prev = 0;
    m_req = 0; m_isnmi = 0; m_level = '0; m_vout = '0; m_id = '0;
    m_back = 0; m_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(input int widx);
    logic [31:0] r;
    r = '0;
    if (widx < NSRC) begin
      r[3:0]  = m_prio[widx];
      r[11:4] = m_vecs[widx];
      r[16]   = m_edge[widx];
    end else if (widx == 16) begin
      for (int k = 0; k < NSRC; k++) r[k] = m_pend[k] && m_edge[k];
    end else if (widx == 17) begin
      r[NSRC-1:0] = src;
      r[16]    = m_nmi_pend;
      r[20:17] = m_id;
      r[21]    = m_req;
    end
    return r;
  endfunction

  // Advance the model across one clock edge using the inputs now applied
  task automatic model_step();
    int widx, win;
    logic [3:0] best;
    logic [7:0] a;
    logic nmi_edge, wnmi, accepted, act, rise;
    if (rst) begin
      model_reset();
      return;
    end
    a = bi.bus_addr;
    widx = int'(a[7:2]);
    nmi_edge = nmi && !m_nmi_prev;
    wnmi = m_nmi_pend || nmi_edge;
    win = -1;
    best = '0;
    for (int k = 0; k < NSRC; k++) begin
      rise = src[k] && !m_prev[k];
      act = m_edge[k] ? (m_pend[k] || rise) : src[k];
      if (act && m_prio[k] > imask && m_prio[k] > best) begin
        best = m_prio[k];
        win = k;
      end
    end
    accepted = bi.inta_ack && m_req;
    m_back  = bi.bus_sel;
    m_rdata = (bi.bus_sel && !bi.bus_we) ? model_read(widx) : '0;
    for (int k = 0; k < NSRC; k++) begin
      if (bi.bus_sel && bi.bus_we && widx == 16 && bi.bus_wdata[k]) m_pend[k] = 1'b0;
      if (accepted && !m_isnmi && m_id == 4'(k)) m_pend[k] = 1'b0;
      if (src[k] && !m_prev[k]) m_pend[k] = 1'b1;
      if (!m_edge[k]) m_pend[k] = 1'b0;
    end
    if (accepted && m_isnmi) m_nmi_pend = 1'b0;
    if (nmi_edge) m_nmi_pend = 1'b1;
    if (accepted || (!wnmi && win < 0)) begin
      m_req = 0; m_isnmi = 0; m_level = '0; m_vout = '0; m_id = '0;
    end else if (wnmi) begin
      m_req = 1; m_isnmi = 1; m_level = 5'h1F; m_vout = 8'h0B; m_id = '0;
    end else begin
      m_req = 1; m_isnmi = 0; m_level = {1'b0, best}; m_vout = m_vecs[win]; m_id = 4'(win);
    end
    if (bi.bus_sel && bi.bus_we && widx < NSRC) begin
      m_prio[widx] = bi.bus_wdata[3:0];
      m_vecs[widx] = bi.bus_wdata[11:4];
      m_edge[widx] = bi.bus_wdata[16];
    end
    for (int k = 0; k < NSRC; k++) m_prev[k] = src[k];
    m_nmi_prev = nmi;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("intr_req",   32'(bi.intr_req),   32'(m_req));
    check("intr_level", 32'(bi.intr_level), 32'(m_level));
    check("intr_vec",   32'(bi.intr_vec),   32'(m_vout));
    check("bus_ack",    32'(bi.bus_ack),    32'(m_back));
    check("bus_rdata",  bi.bus_rdata,       m_rdata);
    bi.bus_sel  = 1'b0;
    bi.bus_we   = 1'b0;
    bi.inta_ack = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    bi.bus_sel = 1'b1; bi.bus_we = 1'b1; bi.bus_addr = addr; bi.bus_wdata = data;
    tick();
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    bi.bus_sel = 1'b1; bi.bus_we = 1'b0; bi.bus_addr = addr; bi.bus_wdata = '0;
    tick();
    data = bi.bus_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bi.bus_sel = 0; bi.bus_we = 0; bi.bus_addr = '0; bi.bus_wdata = '0; bi.inta_ack = 0;
    model_reset();
    #1;
    rst = 1; tick(); tick();
    rst = 0;
    check("rst_req", 32'(bi.intr_req), 32'd0);
    check("rst_vec", 32'(bi.intr_vec), 32'd0);

    // Default CFG_0 after reset
    bus_read(8'h00, d);
    check("cfg0_default", d, 32'h0000_0400);

    // 1: edge source 3, prio 5, vec 0x50
    bus_write(8'h0C, 32'h0001_0505);
    src = 8'h08; tick();
    check("t1_req", 32'(bi.intr_req), 32'd1);
    check("t1_level", 32'(bi.intr_level), 32'h05);
    check("t1_vec", 32'(bi.intr_vec), 32'h50);
    src = 8'h00; bi.inta_ack = 1; tick();
    check("t1_gap", 32'(bi.intr_req), 32'd0);
    tick();
    check("t1_stay_low", 32'(bi.intr_req), 32'd0);
    bus_read(8'h40, d);
    check("t1_pend3", 32'(d[3]), 32'd0);

    // 2: level tie between sources 1 and 2
    bus_write(8'h04, 32'h0000_0417);
    bus_write(8'h08, 32'h0000_0427);
    src = 8'h06; tick();
    check("t2_vec", 32'(bi.intr_vec), 32'h41);
    check("t2_level", 32'(bi.intr_level), 32'h07);
    imask = 4'h7; tick();
    check("t2_masked", 32'(bi.intr_req), 32'd0);
    src = 8'h00; imask = 4'h0; tick();

    // 3: preemption by a higher source before ack
    bus_write(8'h10, 32'h0000_0443);
    bus_write(8'h18, 32'h0001_0469);
    src = 8'h10; tick();
    check("t3_vec4", 32'(bi.intr_vec), 32'h44);
    src = 8'h50; tick();
    check("t3_vec6", 32'(bi.intr_vec), 32'h46);
    check("t3_level6", 32'(bi.intr_level), 32'h09);
    bi.inta_ack = 1; tick();
    check("t3_gap", 32'(bi.intr_req), 32'd0);
    tick();
    check("t3_represent", 32'(bi.intr_vec), 32'h44);
    src = 8'h00; tick();
    check("t3_withdraw", 32'(bi.intr_req), 32'd0);
    bus_read(8'h40, d);
    check("t3_pend", d, 32'd0);

    // 4: NMI overrides a full mask
    imask = 4'hF;
    src = 8'h08; tick();
    src = 8'h00; tick();
    check("t4_masked", 32'(bi.intr_req), 32'd0);
    nmi = 1; tick();
    check("t4_level", 32'(bi.intr_level), 32'h1F);
    check("t4_vec", 32'(bi.intr_vec), 32'h0B);
    bi.inta_ack = 1; tick();
    check("t4_gap", 32'(bi.intr_req), 32'd0);
    tick();
    bus_read(8'h44, d);
    check("t4_nmi_pend", 32'(d[16]), 32'd0);
    bus_read(8'h40, d);
    check("t4_pend3", 32'(d[3]), 32'd1);
    imask = 4'h0; tick();
    check("t4_src3", 32'(bi.intr_vec), 32'h50);
    bi.inta_ack = 1; tick();
    tick();
    nmi = 0; tick();

    // 5: new edge coincident with W1C keeps the bit set
    imask = 4'hF;
    bus_write(8'h00, 32'h0001_0402);
    src = 8'h01;
    bus_write(8'h40, 32'h0000_0001);
    bus_read(8'h40, d);
    check("t5_set_wins", d, 32'h0000_0001);
    src = 8'h00;
    bus_write(8'h40, 32'h0000_0001);
    bus_read(8'h40, d);
    check("t5_cleared", d, 32'd0);
    imask = 4'h0;

    // 6: reset in the middle of a handshake
    nmi = 1; tick();
    check("t6_req", 32'(bi.intr_req), 32'd1);
    rst = 1; bi.inta_ack = 1; nmi = 0; tick();
    rst = 0;
    check("t6_req0", 32'(bi.intr_req), 32'd0);
    check("t6_level0", 32'(bi.intr_level), 32'd0);
    bus_read(8'h40, d);
    check("t6_pend0", d, 32'd0);
    tick(); tick();
    check("t6_quiet", 32'(bi.intr_req), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      src = src ^ NSRC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) nmi = ~nmi;
      if ($urandom_range(0, 15) == 0) imask = 4'($urandom_range(0, 15));
      bi.inta_ack = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) begin
        bi.bus_sel = 1'b1;
        bi.bus_we  = 1'($urandom_range(0, 1));
        bi.bus_addr = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'(4 * $urandom_range(0, 19));
        bi.bus_wdata = $urandom;
      end
      tick();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
